// File: rtl/fp16_pkg.sv
// Shared types and constants for the half-precision iterative square-root stage.
package fp16_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ITER_N_DEFAULT = 11;
   localparam int EXP_W          = 7;
   localparam int MANT_W         = 11;
   localparam int RAD_W          = 2 * MANT_W;
   localparam int REM_W          = 13;

   localparam logic signed [EXP_W-1:0] ZERO_EXP = -7'sd15;

   // An odd exponent is folded into the radicand so the halved exponent stays integral.
   function automatic logic [RAD_W-1:0] radicand(input logic [MANT_W-1:0] mant,
                                                 input logic              odd);
      logic [RAD_W-1:0] r;
      if (odd) begin
         r = {mant, 10'b0, 1'b0};
      end else begin
         r = {1'b0, mant, 10'b0};
      end
      return r;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: brings down a radicand bit pair and
// tries to subtract (4*root + 1) from the widened remainder.
module sqrt_step
   import fp16_pkg::*;
(
   input  logic [REM_W-1:0]  rem_in,
   input  logic [MANT_W-1:0] root_in,
   input  logic [1:0]        pair,
   output logic [REM_W-1:0]  rem_out,
   output logic              root_bit
);

   logic [REM_W+1:0] shifted;
   logic [REM_W+1:0] trial_sub;

   // Trial subtraction; the remainder is restored when the trial would go negative.
   always_comb begin
      shifted   = {rem_in, pair};
      trial_sub = {2'b00, root_in, 2'b01};
      root_bit  = 1'b0;
      rem_out   = {REM_W{1'b0}};
      if (shifted >= trial_sub) begin
         root_bit = 1'b1;
         rem_out  = REM_W'(shifted - trial_sub);
      end else begin
         root_bit = 1'b0;
         rem_out  = REM_W'(shifted);
      end
   end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative half-precision square root: special-case decode, then one root
// bit per enabled cycle through sqrt_step.
module sqrt_iter
   import fp16_pkg::*;
#(
   parameter int ITER_N = ITER_N_DEFAULT
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     u_valid,
   input  logic                     sign_in,
   input  logic signed [EXP_W-1:0]  exp_in,
   input  logic [MANT_W-1:0]        mant_in,
   input  logic                     is_nan_in,
   input  logic                     is_pinf_in,
   input  logic                     is_ninf_in,
   input  logic                     is_zero_in,
   output logic                     busy,
   output logic                     it_valid,
   output logic                     sign_out,
   output logic signed [EXP_W-1:0]  exp_out,
   output logic [MANT_W-1:0]        mant_out,
   output logic                     is_nan_out,
   output logic                     is_pinf_out,
   output logic                     is_ninf_out,
   output logic                     result_out
);

   localparam int              CNT_W    = $clog2(ITER_N + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

   state_t                  state;
   state_t                  state_nx;
   logic [CNT_W-1:0]        cnt;
   logic [REM_W-1:0]        rem;
   logic [MANT_W-1:0]       root;
   logic [RAD_W-1:0]        rad;
   logic signed [EXP_W-1:0] exp_half;

   logic             accept;
   logic             last_step;
   logic             special;
   logic             sp_nan;
   logic             sp_pinf;
   logic             sp_zero;
   logic [REM_W-1:0] rem_nx;
   logic             bit_nx;

   assign accept      = enable & u_valid & (state == IDLE);
   assign last_step   = (cnt == CNT_LAST);
   assign is_ninf_out = 1'b0;

   sqrt_step u_step (
      .rem_in   (rem),
      .root_in  (root),
      .pair     (rad[RAD_W-1 -: 2]),
      .rem_out  (rem_nx),
      .root_bit (bit_nx)
   );

   // Operand classification, highest priority first.
   always_comb begin
      special = 1'b1;
      sp_nan  = 1'b0;
      sp_pinf = 1'b0;
      sp_zero = 1'b0;
      if (is_nan_in) begin
         sp_nan = 1'b1;
      end else if (is_zero_in) begin
         sp_zero = 1'b1;
      end else if (sign_in | is_ninf_in) begin
         sp_nan = 1'b1;
      end else if (is_pinf_in) begin
         sp_pinf = 1'b1;
      end else begin
         special = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state logic; nothing advances while enable is low.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = special ? DONE : CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         CALC: begin
            if (enable && last_step) begin
               state_nx = DONE;
            end else begin
               state_nx = CALC;
            end
         end
         DONE: begin
            if (enable) begin
               state_nx = IDLE;
            end else begin
               state_nx = DONE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy     = (state != IDLE);
      it_valid = (state == DONE) & enable;
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= {CNT_W{1'b0}};
         rem         <= {REM_W{1'b0}};
         root        <= {MANT_W{1'b0}};
         rad         <= {RAD_W{1'b0}};
         exp_half    <= {EXP_W{1'b0}};
         sign_out    <= 1'b0;
         exp_out     <= {EXP_W{1'b0}};
         mant_out    <= {MANT_W{1'b0}};
         is_nan_out  <= 1'b0;
         is_pinf_out <= 1'b0;
         result_out  <= 1'b0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (u_valid && special) begin
                  sign_out    <= sp_zero & sign_in;
                  exp_out     <= sp_zero ? ZERO_EXP : {EXP_W{1'b0}};
                  mant_out    <= {MANT_W{1'b0}};
                  is_nan_out  <= sp_nan;
                  is_pinf_out <= sp_pinf;
                  result_out  <= 1'b1;
               end else if (u_valid) begin
                  cnt      <= {CNT_W{1'b0}};
                  rem      <= {REM_W{1'b0}};
                  root     <= {MANT_W{1'b0}};
                  rad      <= radicand(mant_in, exp_in[0]);
                  exp_half <= exp_in >>> 1;
               end else begin
                  cnt <= cnt;
               end
            end
            CALC: begin
               rem  <= rem_nx;
               root <= {root[MANT_W-2:0], bit_nx};
               rad  <= {rad[RAD_W-3:0], 2'b00};
               if (last_step) begin
                  cnt         <= {CNT_W{1'b0}};
                  sign_out    <= 1'b0;
                  exp_out     <= exp_half;
                  mant_out    <= {root[MANT_W-2:0], bit_nx};
                  is_nan_out  <= 1'b0;
                  is_pinf_out <= 1'b0;
                  result_out  <= (rem_nx == {REM_W{1'b0}});
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sqrt_iter.sv
// Self-checking bench for sqrt_iter: arithmetic reference model, per-cycle
// compare process, directed latency/special/reset cases and random traffic.
module tb_sqrt_iter;

   localparam int ITER = 11;

   logic              clk;
   logic              rst;
   logic              enable;
   logic              u_valid;
   logic              sign_in;
   logic signed [6:0] exp_in;
   logic [10:0]       mant_in;
   logic              is_nan_in, is_pinf_in, is_ninf_in, is_zero_in;
   logic              busy, it_valid, sign_out;
   logic signed [6:0] exp_out;
   logic [10:0]       mant_out;
   logic              is_nan_out, is_pinf_out, is_ninf_out, result_out;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic              special;
      logic              sign;
      logic signed [6:0] e;
      logic [10:0]       m;
      logic              nan;
      logic              pinf;
      logic              res;
   } res_t;

   sqrt_iter #(.ITER_N(ITER)) dut (
      .clk(clk), .rst(rst), .enable(enable), .u_valid(u_valid),
      .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
      .is_nan_in(is_nan_in), .is_pinf_in(is_pinf_in),
      .is_ninf_in(is_ninf_in), .is_zero_in(is_zero_in),
      .busy(busy), .it_valid(it_valid), .sign_out(sign_out),
      .exp_out(exp_out), .mant_out(mant_out),
      .is_nan_out(is_nan_out), .is_pinf_out(is_pinf_out),
      .is_ninf_out(is_ninf_out), .result_out(result_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result from the numeric definition: value = mant/1024 * 2^exp.
   function automatic res_t model_res(input logic s, input logic signed [6:0] e,
                                      input logic [10:0] m, input logic nan,
                                      input logic pinf, input logic ninf,
                                      input logic zero);
      res_t   r;
      longint rr, q;
      int     ei, odd;
      r = '0;
      r.special = 1'b1;
      if (nan) begin
         r.nan = 1'b1; r.res = 1'b1;
      end else if (zero) begin
         r.sign = s; r.e = -7'sd15; r.res = 1'b1;
      end else if (s || ninf) begin
         r.nan = 1'b1; r.res = 1'b1;
      end else if (pinf) begin
         r.pinf = 1'b1; r.res = 1'b1;
      end else begin
         r.special = 1'b0;
         ei  = int'(e);
         odd = ((ei % 2) != 0) ? 1 : 0;
         rr  = longint'(m) * 1024 * ((odd != 0) ? 2 : 1);
         q   = longint'($floor($sqrt(real'(rr))));
         while (q * q > rr) q = q - 1;
         while ((q + 1) * (q + 1) <= rr) q = q + 1;
         r.m   = q[10:0];
         r.e   = 7'((ei - odd) / 2);
         r.res = (q * q == rr);
      end
      return r;
   endfunction

   res_t in_res;
   always_comb in_res = model_res(sign_in, exp_in, mant_in, is_nan_in,
                                  is_pinf_in, is_ninf_in, is_zero_in);

   // Timing model: idle / waiting ITER enabled cycles / presenting a result.
   bit   m_idle = 1'b1;
   bit   m_done = 1'b0;
   int   m_wait = 0;
   res_t m_pend = '0;
   res_t m_out  = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_idle <= 1'b1; m_done <= 1'b0; m_wait <= 0; m_out <= '0;
      end else if (enable) begin
         if (m_idle) begin
            if (u_valid && in_res.special) begin
               m_idle <= 1'b0; m_done <= 1'b1; m_out <= in_res;
            end else if (u_valid) begin
               m_idle <= 1'b0; m_wait <= ITER; m_pend <= in_res;
            end
         end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
               m_done <= 1'b1; m_out <= m_pend;
            end
         end else if (m_done) begin
            m_done <= 1'b0; m_idle <= 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",      32'(busy),        32'(!m_idle));
         chk("it_valid",  32'(it_valid),    32'(m_done && enable));
         chk("sign_out",  32'(sign_out),    32'(m_out.sign));
         chk("exp_out",   32'($unsigned(exp_out)), 32'($unsigned(m_out.e)));
         chk("mant_out",  32'(mant_out),    32'(m_out.m));
         chk("nan_out",   32'(is_nan_out),  32'(m_out.nan));
         chk("pinf_out",  32'(is_pinf_out), 32'(m_out.pinf));
         chk("ninf_out",  32'(is_ninf_out), 32'd0);
         chk("result",    32'(result_out),  32'(m_out.res));
      end
   end

   task automatic wait_idle();
      int i = 0;
      while (!m_idle && i < 60) begin
         @(posedge clk); #1; i++;
      end
      if (!m_idle) begin
         total++; bad++;
         $display("FAIL wait_idle actual=busy required=idle at %0t", $time);
      end
   endtask

   task automatic send(input logic s, input logic signed [6:0] e, input logic [10:0] m,
                       input logic nan, input logic pinf, input logic ninf, input logic zero);
      wait_idle();
      @(posedge clk); #2;
      enable = 1'b1; u_valid = 1'b1;
      sign_in = s; exp_in = e; mant_in = m;
      is_nan_in = nan; is_pinf_in = pinf; is_ninf_in = ninf; is_zero_in = zero;
      @(posedge clk); #2;
      u_valid = 1'b0;
      sign_in = 1'($urandom); exp_in = 7'($urandom); mant_in = 11'($urandom);
      is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0; is_zero_in = 1'b0;
   endtask

   // Counts cycles after the accepting edge until it_valid; enable is low for cycles lo_s..lo_s+lo_n-1.
   task automatic wait_result(input int lo_s, input int lo_n, output int lat, output res_t got);
      lat = 0;
      got = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (it_valid) begin
            lat = c;
            got = {1'b0, sign_out, exp_out, mant_out, is_nan_out, is_pinf_out, result_out};
            break;
         end
         @(posedge clk); #2;
         enable = !(c >= lo_s && c < lo_s + lo_n);
      end
      enable = 1'b1;
   endtask

   task automatic rand_operand();
      int k = int'($urandom_range(9, 0));
      sign_in = (($urandom % 6) == 0);
      is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0; is_zero_in = 1'b0;
      if (k < 7) begin
         exp_in  = 7'(int'($urandom_range(29, 0)) - 14);
         mant_in = (k == 6) ? 11'h400 : {1'b1, 10'($urandom)};
      end else if (k == 7) begin
         exp_in = -7'sd15; mant_in = 11'h000; is_zero_in = 1'b1;
      end else if (k == 8) begin
         exp_in = 7'sd16; mant_in = 11'h400;
         is_pinf_in = !sign_in; is_ninf_in = sign_in;
      end else begin
         exp_in = 7'sd16; mant_in = 11'h600; is_nan_in = 1'b1;
      end
   endtask

   int   lat;
   int   seen;
   res_t got;
   res_t pin;

   initial begin
      rst = 1'b0; enable = 1'b0; u_valid = 1'b0;
      sign_in = 1'b0; exp_in = 7'sd0; mant_in = 11'h000;
      is_nan_in = 1'b0; is_pinf_in = 1'b0; is_ninf_in = 1'b0; is_zero_in = 1'b0;
      #1 rst = 1'b1;
      chk_en = 1'b1;

      pin = model_res(1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("model_4p0_mant", 32'(pin.m), 32'h400);
      pin = model_res(1'b0, 7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("model_2p0_mant", 32'(pin.m), 32'h5A8);
      chk("model_2p0_res",  32'(pin.res), 32'd0);
      pin = model_res(1'b0, -7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("model_0p5_exp",  32'($unsigned(pin.e)), 32'h7F);

      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mant", 32'(mant_out), 32'd0);
      chk("rst_exp",  32'($unsigned(exp_out)), 32'd0);
      @(posedge clk); #2 rst = 1'b0;

      send(1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("lat_4p0", 32'(lat), 32'd12);
      chk("mant_4p0", 32'(got.m), 32'h400);
      chk("exp_4p0", 32'($unsigned(got.e)), 32'h01);
      chk("res_4p0", 32'(got.res), 32'd1);

      send(1'b0, 7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("lat_2p0", 32'(lat), 32'd12);
      chk("mant_2p0", 32'(got.m), 32'h5A8);
      chk("exp_2p0", 32'($unsigned(got.e)), 32'h00);
      chk("res_2p0", 32'(got.res), 32'd0);

      send(1'b0, -7'sd1, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("mant_0p5", 32'(got.m), 32'h5A8);
      chk("exp_0p5", 32'($unsigned(got.e)), 32'h7F);

      send(1'b1, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("lat_neg4", 32'(lat), 32'd1);
      chk("nan_neg4", 32'(got.nan), 32'd1);
      chk("res_neg4", 32'(got.res), 32'd1);

      send(1'b1, -7'sd15, 11'h000, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_result(0, 0, lat, got);
      chk("lat_nzero", 32'(lat), 32'd1);
      chk("sign_nzero", 32'(got.sign), 32'd1);
      chk("exp_nzero", 32'($unsigned(got.e)), 32'h71);
      chk("mant_nzero", 32'(got.m), 32'h000);

      send(1'b0, 7'sd16, 11'h400, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("lat_pinf", 32'(lat), 32'd1);
      chk("pinf_pinf", 32'(got.pinf), 32'd1);
      chk("exp_pinf", 32'($unsigned(got.e)), 32'h00);

      send(1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(3, 5, lat, got);
      chk("lat_stall", 32'(lat), 32'd17);
      chk("mant_stall", 32'(got.m), 32'h400);

      send(1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #2;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(it_valid), 32'd0);
      chk("abort_mant", 32'(mant_out), 32'd0);
      chk("abort_res", 32'(result_out), 32'd0);
      @(posedge clk); #2 rst = 1'b0;
      seen = 0;
      repeat (15) begin
         @(negedge clk);
         if (it_valid) seen++;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
      send(1'b0, 7'sd2, 11'h400, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_result(0, 0, lat, got);
      chk("lat_after_rst", 32'(lat), 32'd12);
      chk("mant_after_rst", 32'(got.m), 32'h400);
      chk("res_after_rst", 32'(got.res), 32'd1);

      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         enable  = (($urandom % 10) != 0);
         u_valid = (($urandom % 3) == 0);
         rand_operand();
      end
      @(posedge clk); #2;
      enable = 1'b1; u_valid = 1'b0;
      wait_idle();
      repeat (2) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/sqrt_iter.md
SQRT_ITER -- requirements
Module: sqrt_iter

Interface
REQ-001 Parameter ITER_N, default 11, is the number of root bits produced, one per iteration.
REQ-002 Ports (clock and reset first):
- clk  in  1  — sole clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- enable  in  1  — stage enable; low freezes the stage.
- u_valid  in  1  — operand valid from unpack.
- sign_in  in  1  — operand sign.
- exp_in  in  7 signed  — unbiased exponent; -15 for zero.
- mant_in  in  11  — significand with hidden bit; mant_in[10]=1 for finite nonzero.
- is_nan_in, is_pinf_in, is_ninf_in, is_zero_in  in  1 each  — operand class.
- busy  out  1  — stage not idle.
- it_valid  out  1  — one-cycle result strobe to pack.
- sign_out  out  1; exp_out  out  7 signed; mant_out  out  11  — root in pack input format.
- is_nan_out, is_pinf_out, is_ninf_out  out  1 each  — result class.
- result_out  out  1  — root exact (zero remainder) or special result.

Function
REQ-003 The FSM SHALL have states IDLE, CALC and DONE.
REQ-004 Transitions:
- IDLE→CALC on enable&u_valid with a numeric nonzero operand.
- IDLE→DONE on enable&u_valid with a special or zero operand.
- CALC→DONE after ITER_N enabled cycles.
- DONE→IDLE after one enabled cycle.
REQ-005 u_valid SHALL be ignored unless the state is IDLE; busy = (state≠IDLE).
REQ-006 Operand fields SHALL be captured into internal registers on the accepting edge; later input changes have no effect.
REQ-007 Numeric path:
- odd = exp_in[0].
- Radicand R = {mant_in, 10'b0} shifted left by odd, 22 bits.
- exp_out = exp_in arithmetic-shifted right by 1 (floor division).
REQ-008 CALC SHALL perform restoring square root, one bit per cycle MSB-first, with a 13-bit partial remainder and a 2-bit radicand shift per step.
REQ-009 The final root Q SHALL equal floor(sqrt(R)) truncated, with Q[10]=1; no rounding.
REQ-010 In the numeric path, mant_out=Q, sign_out=0, result_out=(final remainder==0), and all flags are 0.
REQ-011 Special/zero mapping, in priority order:
- NaN → is_nan_out.
- Zero (either sign) → sign_out=sign_in, exp_out=-15, mant_out=0, result_out=1.
- Negative nonzero or -inf → is_nan_out.
- +inf → is_pinf_out.
REQ-012 In every special case except zero, result_out=1, mant_out=0 and exp_out=0.
REQ-013 is_ninf_out SHALL always be 0, since sqrt never yields -inf; the port is kept for interface uniformity.
REQ-014 Latency:
- numeric: it_valid high ITER_N+1 cycles after the accepting edge.
- special/zero: it_valid high 1 cycle after the accepting edge.
REQ-015 it_valid = (state==DONE)&enable, high for exactly one enabled cycle.
REQ-016 Result outputs SHALL be registered, change only on entry to DONE, and hold until the next result.
REQ-017 With enable low, state, iteration counter and remainder SHALL freeze and it_valid SHALL be 0; operation resumes unchanged when enable returns.
REQ-018 Back-to-back: a new operand is accepted no earlier than the cycle after DONE; maximum throughput is one numeric result per ITER_N+2 cycles.

Reset
REQ-019 rst high SHALL immediately force the FSM to IDLE, the counter and remainder to 0, and all outputs to 0 (exp_out=0), regardless of clk or enable.
REQ-020 Reset mid-CALC SHALL abort the operation with no it_valid pulse; the first operand after reset release SHALL compute correctly.

Structure
REQ-021 Package fp16_pkg SHALL hold:
- the state enumeration;
- ITER_N_DEFAULT=11;
- ZERO_EXP=-15;
- the widths EXP_W=7 and MANT_W=11.
REQ-022 Sub-module sqrt_step SHALL implement one combinational restoring iteration: (remainder, root, next radicand pair) → (remainder', root bit).
REQ-023 The top level SHALL hold the FSM, counter, operand/remainder/root registers and the special-case decode.

Verification
REQ-024 exp_in=2, mant_in=0x400 (4.0) → exp_out=1, mant_out=0x400, result_out=1, it_valid 12 cycles after accept.
REQ-025 exp_in=1, mant_in=0x400 (2.0) → exp_out=0, mant_out=0x5A8, result_out=0.
REQ-026 exp_in=-1, mant_in=0x400 (0.5) → exp_out=-1, mant_out=0x5A8.
REQ-027 Specials, each with it_valid 1 cycle after accept:
- sign_in=1, exp_in=2 (-4.0) → is_nan_out=1.
- -0 → sign_out=1, exp_out=-15, mant_out=0.
- +inf → is_pinf_out=1.
REQ-028 enable low for 5 cycles mid-CALC → no it_valid while low; the 4.0 result arrives 17 cycles after accept.
REQ-029 rst pulsed at CALC cycle 6 → outputs 0, no it_valid, busy=0; the next 4.0 operand yields the REQ-024 result.
